// File: rtl/spi_bram_pkg.sv
// Shared opcodes, FSM state type and the status-byte packer for spi_bram_bridge.
package spi_bram_pkg;

  // Command opcodes (first byte of every frame)
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;

  // Command engine states
  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StLen,
    StWrData,
    StRdIssue,
    StRdPush
  } state_e;

  // Layout of the byte returned by the STATUS opcode
  function automatic logic [7:0] status_byte(input logic sticky_err, input logic [1:0] last_op);
    return {sticky_err, 3'b000, last_op, 2'b00};
  endfunction

endpackage

// File: rtl/spi_bram_mem.sv
// Single-port byte RAM: synchronous write, registered read with read enable.
// Kept free of control logic so the array maps onto block RAM.
module spi_bram_mem #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [7:0]  INIT_VALUE = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  // Power-up content only; rst never clears the array
  logic [7:0] mem_q [Depth] = '{default: INIT_VALUE};
  logic [7:0] rdata_q;

  // Array write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Output register; holds its value while re is low
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 8'h00;
    end else if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spi_bram_bridge.sv
// Framed byte-stream command engine between the SPI RX/TX FIFO streams and an
// inferred BRAM. Frame: OP, ADDR (MSB first), LEN, payload; bursts are LEN+1 bytes.
// Optional STATUS opcode enabled by defining SPI_BRAM_BRIDGE_STATUS_EN.
module spi_bram_bridge
  import spi_bram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [7:0]  INIT_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       frame_abort,
  output logic       busy,
  output logic       cmd_err
);

  localparam int unsigned ADDR_BYTES    = (ADDR_WIDTH + 7) / 8;
  localparam logic [1:0]  LAST_ADDR_BYTE = 2'(ADDR_BYTES - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] addr_shifted;
  logic [7:0]            count_q, count_d;
  logic [1:0]            abyte_q, abyte_d;
  logic                  is_read_q, is_read_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  rx_fire, tx_fire;
  logic                  mem_we, mem_re;
  logic [7:0]            mem_rdata;

`ifdef SPI_BRAM_BRIDGE_STATUS_EN
  logic       sticky_q, sticky_d;
  logic [1:0] last_op_q, last_op_d;
  logic       status_sel_q, status_sel_d;
  logic [7:0] status_q, status_d;
`endif

  // The bridge always sinks RX bytes; bytes arriving during reads are dummies
  assign rx_ready = 1'b1;
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid_q && tx_ready;

  // Shift the next address byte in; bits above ADDR_WIDTH fall off the top
  if (ADDR_WIDTH > 8) begin : g_addr_wide
    assign addr_shifted = {addr_q[ADDR_WIDTH-9:0], rx_data};
  end else begin : g_addr_narrow
    assign addr_shifted = rx_data[ADDR_WIDTH-1:0];
  end

  // Next-state, datapath updates and BRAM strobes
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    abyte_d    = abyte_q;
    is_read_d  = is_read_q;
    tx_valid_d = tx_valid_q;
    cmd_err_d  = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
`ifdef SPI_BRAM_BRIDGE_STATUS_EN
    sticky_d     = sticky_q;
    last_op_d    = last_op_q;
    status_sel_d = status_sel_q;
    status_d     = status_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (rx_fire) begin
          if (rx_data == OP_WRITE || rx_data == OP_READ) begin
            is_read_d = (rx_data == OP_READ);
            abyte_d   = 2'd0;
            state_d   = StAddr;
`ifdef SPI_BRAM_BRIDGE_STATUS_EN
            last_op_d = rx_data[1:0];
`endif
          end
`ifdef SPI_BRAM_BRIDGE_STATUS_EN
          else if (rx_data == OP_STATUS) begin
            // Snapshot before last_op is overwritten by this opcode
            status_d     = status_byte(sticky_q, last_op_q);
            status_sel_d = 1'b1;
            last_op_d    = rx_data[1:0];
            count_d      = 8'd0;
            tx_valid_d   = 1'b1;
            state_d      = StRdPush;
          end
`endif
          else begin
            cmd_err_d = 1'b1;
          end
        end
      end

      StAddr: begin
        if (rx_fire) begin
          addr_d = addr_shifted;
          if (abyte_q == LAST_ADDR_BYTE) begin
            abyte_d = 2'd0;
            state_d = StLen;
          end else begin
            abyte_d = abyte_q + 2'd1;
          end
        end
      end

      StLen: begin
        if (rx_fire) begin
          count_d = rx_data;
          state_d = is_read_q ? StRdIssue : StWrData;
        end
      end

      StWrData: begin
        if (rx_fire) begin
          mem_we = 1'b1;
          addr_d = addr_q + 1'b1;
          if (count_q == 8'd0) begin
            state_d = StIdle;
          end else begin
            count_d = count_q - 8'd1;
          end
        end
      end

      StRdIssue: begin
        // One cycle of read latency; the RAM output register becomes tx_data
        mem_re     = 1'b1;
        tx_valid_d = 1'b1;
        state_d    = StRdPush;
`ifdef SPI_BRAM_BRIDGE_STATUS_EN
        status_sel_d = 1'b0;
`endif
      end

      StRdPush: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
`ifdef SPI_BRAM_BRIDGE_STATUS_EN
          if (status_sel_q) begin
            sticky_d = 1'b0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
`else
          addr_d = addr_q + 1'b1;
`endif
          if (count_q == 8'd0) begin
            state_d = StIdle;
          end else begin
            count_d = count_q - 8'd1;
            state_d = StRdIssue;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides everything but rst; a write strobed this cycle still lands
    if (frame_abort) begin
      state_d    = StIdle;
      tx_valid_d = 1'b0;
      cmd_err_d  = (state_q != StIdle);
`ifdef SPI_BRAM_BRIDGE_STATUS_EN
      last_op_d  = last_op_q;
`endif
    end

`ifdef SPI_BRAM_BRIDGE_STATUS_EN
    if (cmd_err_d) begin
      sticky_d = 1'b1;
    end
`endif
  end

  // Control and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      count_q    <= 8'd0;
      abyte_q    <= 2'd0;
      is_read_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      abyte_q    <= abyte_d;
      is_read_q  <= is_read_d;
      tx_valid_q <= tx_valid_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

`ifdef SPI_BRAM_BRIDGE_STATUS_EN
  // Status registers: sticky error, last opcode, and the pending status byte
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q     <= 1'b0;
      last_op_q    <= 2'd0;
      status_sel_q <= 1'b0;
      status_q     <= 8'h00;
    end else begin
      sticky_q     <= sticky_d;
      last_op_q    <= last_op_d;
      status_sel_q <= status_sel_d;
      status_q     <= status_d;
    end
  end

  assign tx_data = status_sel_q ? status_q : mem_rdata;
`else
  assign tx_data = mem_rdata;
`endif

  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;
  assign busy     = (state_q != StIdle);

  spi_bram_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_VALUE (INIT_VALUE)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (addr_q),
    .wdata (rx_data),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_spi_bram_bridge.sv
// Scoreboarded bench for spi_bram_bridge: commands are issued as byte frames,
// expected TX bytes are queued from an array model of the RAM, and a monitor
// pops and compares on every TX handshake.
module tb_spi_bram_bridge;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned AB    = (AW + 7) / 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       frame_abort = 1'b0;
  logic       busy;
  logic       cmd_err;

  int         checks = 0;
  int         errors = 0;
  int         err_cycles = 0;
  bit         rand_ready = 1'b1;
  logic [7:0] model_mem [DEPTH];
  logic [7:0] exp_q [$];
  bit         sticky_m = 1'b0;
  logic [1:0] last_op_m = 2'd0;

  spi_bram_bridge #(
    .ADDR_WIDTH (AW),
    .INIT_VALUE (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .frame_abort (frame_abort),
    .busy        (busy),
    .cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every TX handshake against the scoreboard; count cmd_err cycles
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_err) err_cycles++;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got %0h expected no byte", tx_data);
        end else begin
          check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Random TX back-pressure
  always @(posedge clk) begin
    #1;
    if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] op, input int addr, input int len);
    send_byte(op, $urandom_range(0, 1));
    for (int i = AB - 1; i >= 0; i--) send_byte(8'(addr >> (8 * i)), $urandom_range(0, 1));
    send_byte(8'(len), $urandom_range(0, 1));
  endtask

  task automatic do_write(input int addr, input logic [7:0] data[$]);
    send_hdr(8'h01, addr, data.size() - 1);
    last_op_m = 2'd1;
    for (int i = 0; i < data.size(); i++) begin
      model_mem[(addr + i) % DEPTH] = data[i];
      send_byte(data[i], $urandom_range(0, 2));
    end
  endtask

  // Feed dummy bytes while busy until every queued byte has been handshaken
  task automatic drain(input string name);
    int n;
    for (n = 0; n < 3000; n++) begin
      if (!busy && exp_q.size() == 0) break;
      rx_valid = busy && ($urandom_range(0, 1) == 1);
      rx_data  = 8'($urandom);
      tick();
    end
    rx_valid = 1'b0;
    if (n == 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
    tick();
    check({name, "_busy_done"}, busy, 1'b0);
    check({name, "_txv_done"}, tx_valid, 1'b0);
  endtask

  task automatic do_read(input int addr, input int len);
    for (int i = 0; i <= len; i++) exp_q.push_back(model_mem[(addr + i) % DEPTH]);
    last_op_m = 2'd2;
    send_hdr(8'h02, addr, len);
    drain("read");
  endtask

  task automatic bad_op(input logic [7:0] op);
    int e0;
    e0 = err_cycles;
    send_byte(op, 0);
    for (int i = 0; i < 3; i++) begin
      check("bad_op_busy", busy, 1'b0);
      tick();
    end
    check("bad_op_err_pulse", err_cycles - e0, 1);
    sticky_m = 1'b1;
  endtask

`ifdef SPI_BRAM_BRIDGE_STATUS_EN
  task automatic do_status();
    exp_q.push_back({sticky_m, 3'b000, last_op_m, 2'b00});
    sticky_m  = 1'b0;
    last_op_m = 2'd3;
    send_byte(8'h03, 0);
    drain("status");
  endtask
`endif

  task automatic wait_txv(input string name);
    int n;
    for (n = 0; n < 20 && !tx_valid; n++) tick();
    if (!tx_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_wait: got tx_valid 0 expected 1", name);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] dq[$];
    int         a, e0;

    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_rx_ready", rx_ready, 1'b1);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_err", cmd_err, 1'b0);

    // Untouched memory reads back the init value
    do_read(12'h200 % DEPTH, 3);

    // Basic write / read burst
    dq.delete();
    dq.push_back(8'hAA); dq.push_back(8'hBB); dq.push_back(8'hCC); dq.push_back(8'hDD);
    do_write(0, dq);
    do_read(0, 3);

    // Wrap across the top address
    dq.delete();
    dq.push_back(8'h11); dq.push_back(8'h22); dq.push_back(8'h33); dq.push_back(8'h44);
    do_write(DEPTH - 2, dq);
    do_read(DEPTH - 2, 3);
    do_read(0, 1);

    // Back-pressure: output held stable while tx_ready is low
    rand_ready = 1'b0;
    tx_ready   = 1'b0;
    a = $urandom_range(0, DEPTH - 1);
    for (int i = 0; i < 2; i++) exp_q.push_back(model_mem[(a + i) % DEPTH]);
    last_op_m = 2'd2;
    send_hdr(8'h02, a, 1);
    wait_txv("stall");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_tx_valid", tx_valid, 1'b1);
      check("stall_tx_data", tx_data, exp_q[0]);
    end
    tick();
    tx_ready   = 1'b1;
    rand_ready = 1'b1;
    drain("stall");

    // Unknown opcode, then a normal command is still decoded
    bad_op(8'h7E);
    dq.delete();
    for (int i = 0; i < 3; i++) dq.push_back(8'($urandom));
    do_write(5, dq);
    do_read(4, 4);

    // Abort on the second of four write bytes: first two committed, rest untouched
    a = $urandom_range(0, DEPTH - 1);
    e0 = err_cycles;
    send_hdr(8'h01, a, 3);
    last_op_m = 2'd1;
    model_mem[a % DEPTH] = 8'h5A;
    send_byte(8'h5A, 0);
    model_mem[(a + 1) % DEPTH] = 8'hA5;
    rx_valid = 1'b1;
    rx_data = 8'hA5;
    frame_abort = 1'b1;
    tick();
    rx_valid = 1'b0;
    frame_abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    tick();
    tick();
    check("abort_err_pulse", err_cycles - e0, 1);
    sticky_m = 1'b1;
    do_read(a, 3);

`ifdef SPI_BRAM_BRIDGE_STATUS_EN
    bad_op(8'hC3);
    do_status();
    do_status();
`endif

    // Full 256-byte burst wrapping the top
    dq.delete();
    for (int i = 0; i < 256; i++) dq.push_back(8'($urandom));
    do_write(DEPTH - 100, dq);
    do_read(DEPTH - 100, 255);

    // Randomised command mix
    for (int it = 0; it < 40; it++) begin
      int r;
      logic [7:0] op;
      r = $urandom_range(0, 9);
      a = $urandom_range(0, DEPTH - 1);
      if (r < 4) begin
        dq.delete();
        for (int i = 0, n = $urandom_range(1, 16); i < n; i++) dq.push_back(8'($urandom));
        do_write(a, dq);
      end else if (r < 8) begin
        do_read(a, $urandom_range(0, 15));
      end else if (r == 8) begin
        do op = 8'($urandom); while (op == 8'h01 || op == 8'h02 || op == 8'h03);
        bad_op(op);
      end else begin
`ifdef SPI_BRAM_BRIDGE_STATUS_EN
        do_status();
`else
        do_read(DEPTH - 3, 7);
`endif
      end
    end

    // Reset in the middle of a read drops the pending byte
    rand_ready = 1'b0;
    tx_ready   = 1'b0;
    send_hdr(8'h02, 16, 3);
    wait_txv("rst_read");
    rst = 1'b1;
    tick();
    check("rst_mid_tx_valid", tx_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_tx_data", tx_data, 8'h00);
    rst = 1'b0;
    sticky_m  = 1'b0;
    last_op_m = 2'd0;
    tx_ready   = 1'b1;
    rand_ready = 1'b1;
    tick();

    // Memory survives rst and the bridge works afterwards
    do_read(DEPTH - 2, 5);
    dq.delete();
    for (int i = 0; i < 4; i++) dq.push_back(8'($urandom));
    do_write(16, dq);
    do_read(14, 7);
`ifdef SPI_BRAM_BRIDGE_STATUS_EN
    do_status();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
